// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master CPU memory bus arbiter.
package bus_arbiter_pkg;

    // Arbiter FSM encodings
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Read data returned to a master whose transaction was killed by the watchdog
    localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin bus arbiter with a hung-transaction watchdog.
// Master 0 is instruction fetch, master 1 is the load/store unit.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (instruction fetch)
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_lanes,
    input  logic [31:0] m0_dout,
    input  logic        m0_wr,
    input  logic        m0_valid,
    output logic        m0_ready,
    output logic [31:0] m0_din,
    output logic        m0_err,
    // master 1 (load/store)
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_lanes,
    input  logic [31:0] m1_dout,
    input  logic        m1_wr,
    input  logic        m1_valid,
    output logic        m1_ready,
    output logic [31:0] m1_din,
    output logic        m1_err,
    // slave side
    output logic [31:0] s_addr,
    output logic [3:0]  s_lanes,
    output logic [31:0] s_dout,
    output logic        s_wr,
    output logic        s_valid,
    input  logic [31:0] s_din,
    input  logic        s_ready
);

    // A zero TIMEOUT turns the watchdog off entirely
    localparam bit            WDOG_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    arb_state_t    state_reg;
    logic          g_reg;       // master owning the current transaction
    logic          last_reg;    // master granted most recently
    logic [TW-1:0] cnt_reg;     // BUSY cycles spent waiting for s_ready

    logic          winner;
    logic          any_req;
    logic [31:0]   pick_addr;
    logic [3:0]    pick_lanes;
    logic [31:0]   pick_dout;
    logic          pick_wr;
    logic          busy;
    logic          slave_done;
    logic          timeout_hit;
    logic          complete;
    logic [31:0]   resp_data;

    // Round-robin pick: a lone requester wins, a tie goes to the master not served last
    always_comb begin
        any_req = m0_valid | m1_valid;
        winner  = 1'b0;
        if (m0_valid && m1_valid) begin
            winner = ~last_reg;
        end else if (m1_valid) begin
            winner = 1'b1;
        end
        pick_addr  = winner ? m1_addr  : m0_addr;
        pick_lanes = winner ? m1_lanes : m0_lanes;
        pick_dout  = winner ? m1_dout  : m0_dout;
        pick_wr    = winner ? m1_wr    : m0_wr;
    end

    // Completion detection and response routing; a real s_ready beats a same-cycle timeout
    always_comb begin
        busy        = (state_reg == ARB_BUSY);
        slave_done  = busy && s_ready;
        timeout_hit = WDOG_EN && busy && !s_ready && (cnt_reg == TO_LAST);
        complete    = slave_done || timeout_hit;
        resp_data   = timeout_hit ? BUS_ERR_DATA : s_din;

        m0_ready = complete && !g_reg;
        m1_ready = complete &&  g_reg;
        m0_err   = timeout_hit && !g_reg;
        m1_err   = timeout_hit &&  g_reg;
        m0_din   = m0_ready ? resp_data : 32'h0;
        m1_din   = m1_ready ? resp_data : 32'h0;
    end

    // Arbiter FSM: latch the winner's payload on grant, hold it stable until completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB_IDLE;
            g_reg     <= 1'b0;
            last_reg  <= 1'b1;
            cnt_reg   <= '0;
            s_addr    <= 32'h0;
            s_lanes   <= 4'h0;
            s_dout    <= 32'h0;
            s_wr      <= 1'b0;
            s_valid   <= 1'b0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (any_req) begin
                        s_addr    <= pick_addr;
                        s_lanes   <= pick_lanes;
                        s_dout    <= pick_dout;
                        s_wr      <= pick_wr;
                        s_valid   <= 1'b1;
                        g_reg     <= winner;
                        last_reg  <= winner;
                        cnt_reg   <= '0;
                        state_reg <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (complete) begin
                        s_valid   <= 1'b0;
                        state_reg <= ARB_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    s_valid   <= 1'b0;
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (watchdog shortened to 4 cycles).
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m1_addr, m0_dout, m1_dout, m0_din, m1_din;
    logic [3:0]  m0_lanes, m1_lanes, s_lanes;
    logic        m0_wr, m1_wr, m0_valid, m1_valid, m0_ready, m1_ready, m0_err, m1_err;
    logic [31:0] s_addr, s_dout, s_din;
    logic        s_wr, s_valid, s_ready;

    int n_checks = 0;
    int n_fail   = 0;

    bus_arbiter #(.TIMEOUT(4), .TW(8)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_lanes(m0_lanes), .m0_dout(m0_dout), .m0_wr(m0_wr),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_din(m0_din), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_lanes(m1_lanes), .m1_dout(m1_dout), .m1_wr(m1_wr),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_din(m1_din), .m1_err(m1_err),
        .s_addr(s_addr), .s_lanes(s_lanes), .s_dout(s_dout), .s_wr(s_wr),
        .s_valid(s_valid), .s_din(s_din), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_addr = 0; m0_lanes = 4'hF; m0_dout = 0; m0_wr = 0; m0_valid = 0;
        m1_addr = 0; m1_lanes = 4'hF; m1_dout = 0; m1_wr = 0; m1_valid = 0;
        s_din = 0; s_ready = 0;
        #12;
        chk("rst_s_valid", {31'b0, s_valid}, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_wr", {31'b0, s_wr}, 32'h0);
        chk("rst_s_lanes", {28'b0, s_lanes}, 32'h0);
        chk("rst_s_dout", s_dout, 32'h0);
        tick();
        rst = 1'b0;

        // ---- single read by m1, slave answers in the 3rd BUSY cycle
        m1_valid = 1; m1_addr = 32'h100; m1_wr = 0; #1;
        chk("rd_idle_s_valid", {31'b0, s_valid}, 32'h0);
        tick();
        chk("rd_s_valid", {31'b0, s_valid}, 32'h1);
        chk("rd_s_addr", s_addr, 32'h100);
        chk("rd_s_wr", {31'b0, s_wr}, 32'h0);
        chk("rd_m1_ready_early", {31'b0, m1_ready}, 32'h0);
        tick();
        chk("rd_m1_ready_wait", {31'b0, m1_ready}, 32'h0);
        tick();
        s_ready = 1; s_din = 32'hDEADBEEF; #1;
        chk("rd_m1_ready", {31'b0, m1_ready}, 32'h1);
        chk("rd_m1_din", m1_din, 32'hDEADBEEF);
        chk("rd_m1_err", {31'b0, m1_err}, 32'h0);
        chk("rd_m0_ready", {31'b0, m0_ready}, 32'h0);
        chk("rd_m0_din", m0_din, 32'h0);
        tick();
        m1_valid = 0; s_ready = 0; #1;
        chk("rd_s_valid_low", {31'b0, s_valid}, 32'h0);
        chk("rd_m1_ready_low", {31'b0, m1_ready}, 32'h0);

        // ---- simultaneous requests after a fresh reset: m0 first
        rst = 1; #1; rst = 0;
        m0_valid = 1; m0_addr = 32'h0; m0_wr = 0;
        m1_valid = 1; m1_addr = 32'h200; m1_wr = 1; m1_dout = 32'h12345678;
        tick();
        chk("sim_first_addr", s_addr, 32'h0);
        chk("sim_first_wr", {31'b0, s_wr}, 32'h0);
        s_ready = 1; s_din = 32'h55; #1;
        chk("sim_m0_ready", {31'b0, m0_ready}, 32'h1);
        chk("sim_m1_not_ready", {31'b0, m1_ready}, 32'h0);
        tick();
        m0_valid = 0; s_ready = 0; #1;
        chk("sim_gap_idle", {31'b0, s_valid}, 32'h0);
        tick();
        chk("sim_second_valid", {31'b0, s_valid}, 32'h1);
        chk("sim_second_addr", s_addr, 32'h200);
        chk("sim_second_wr", {31'b0, s_wr}, 32'h1);
        chk("sim_second_dout", s_dout, 32'h12345678);
        s_ready = 1; #1;
        chk("sim_m1_ready", {31'b0, m1_ready}, 32'h1);
        tick();
        m1_valid = 0; s_ready = 0; m1_wr = 0;

        // ---- fairness: both held valid, grants must alternate 0,1,0,1...
        m0_valid = 1; m0_addr = 32'h1000;
        m1_valid = 1; m1_addr = 32'h2000;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rr%0d_addr", i), s_addr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
            s_ready = 1; s_din = 32'(i); #1;
            chk($sformatf("rr%0d_m0_ready", i), {31'b0, m0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("rr%0d_m1_ready", i), {31'b0, m1_ready}, (i % 2 == 0) ? 32'h0 : 32'h1);
            tick();
            s_ready = 0;
        end
        m0_valid = 0; m1_valid = 0;
        tick();

        // ---- timeout: m0 read, slave never answers
        m0_valid = 1; m0_addr = 32'h300;
        tick();
        chk("to_s_valid", {31'b0, s_valid}, 32'h1);
        chk("to_c1_ready", {31'b0, m0_ready}, 32'h0);
        tick();
        tick();
        chk("to_c3_ready", {31'b0, m0_ready}, 32'h0);
        chk("to_c3_err", {31'b0, m0_err}, 32'h0);
        tick();
        chk("to_c4_ready", {31'b0, m0_ready}, 32'h1);
        chk("to_c4_err", {31'b0, m0_err}, 32'h1);
        chk("to_c4_din", m0_din, 32'hFFFFFFFF);
        chk("to_c4_m1_ready", {31'b0, m1_ready}, 32'h0);
        tick();
        m0_valid = 0; #1;
        chk("to_after_s_valid", {31'b0, s_valid}, 32'h0);
        s_ready = 1; s_din = 32'h77; #1;
        chk("to_late_m0_ready", {31'b0, m0_ready}, 32'h0);
        chk("to_late_m1_ready", {31'b0, m1_ready}, 32'h0);
        tick();
        s_ready = 0;

        // ---- race: s_ready in the 4th BUSY cycle wins over the watchdog
        m1_valid = 1; m1_addr = 32'h400;
        tick();
        tick();
        tick();
        tick();
        s_ready = 1; s_din = 32'hCAFEF00D; #1;
        chk("race_m1_ready", {31'b0, m1_ready}, 32'h1);
        chk("race_m1_err", {31'b0, m1_err}, 32'h0);
        chk("race_m1_din", m1_din, 32'hCAFEF00D);
        tick();
        m1_valid = 0; s_ready = 0;
        tick();

        // ---- async reset mid-transaction; last grant was m0, reset makes m0 win again
        m0_valid = 1; m0_addr = 32'h500;
        tick();
        chk("ar_busy_s_valid", {31'b0, s_valid}, 32'h1);
        #2 rst = 1; #1;
        chk("ar_s_valid_clear", {31'b0, s_valid}, 32'h0);
        chk("ar_s_addr_clear", s_addr, 32'h0);
        chk("ar_m0_ready", {31'b0, m0_ready}, 32'h0);
        #1 rst = 0;
        m0_valid = 1; m0_addr = 32'h600;
        m1_valid = 1; m1_addr = 32'h700;
        tick();
        chk("ar_tie_addr", s_addr, 32'h600);
        s_ready = 1; #1;
        chk("ar_tie_m0_ready", {31'b0, m0_ready}, 32'h1);
        tick();
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
